euler_angle_reader: RTL

Periodic BNO055 Euler-angle fetcher sitting directly upstream of the roll/pitch attitude encoder. On a fixed sample tick it requests a 6-byte burst read (registers 0x1A–0x1F) from the shared I2C master. It assembles the little-endian bytes into signed 16-bit heading, roll and pitch (16 LSB = 1 deg) and presents them as stable words with a one-cycle valid pulse. Roll and pitch feed the encoder's raw inputs directly; failed or malformed bursts never disturb the presented values.

---
 rtl/euler_angle_reader_if.sv | 24 ++
 rtl/euler_angle_reader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/euler_angle_reader_if.sv
// Burst-read request/response bus between the Euler-angle reader
// (master side) and the shared I2C master (slave side).
interface euler_angle_reader_if;
    logic       o_Rd_Req;
    logic [7:0] o_Rd_Addr;
    logic [2:0] o_Rd_Len;
    logic       i_Rd_Ack;
    logic       i_Byte_Valid;
    logic [7:0] i_Byte;
    logic       i_Rd_Done;
    logic       i_Rd_Err;

    modport master (
        output o_Rd_Req, o_Rd_Addr, o_Rd_Len,
        input  i_Rd_Ack, i_Byte_Valid, i_Byte,
        input  i_Rd_Done, i_Rd_Err
    );

    modport slave (
        input  o_Rd_Req, o_Rd_Addr, o_Rd_Len,
        output i_Rd_Ack, i_Byte_Valid, i_Byte,
        output i_Rd_Done, i_Rd_Err
    );
endinterface

// File: rtl/euler_angle_reader.sv
// Periodic BNO055 Euler-angle fetcher: 6-byte burst from 0x1A.
// Ports: i_Clk/i_Rst_L/i_Enable, rd (I2C burst bus), raw angle words,
// o_Valid pulse, o_Err_Count, o_Stale.
module euler_angle_reader #(
    parameter int CLK_HZ         = 12000000,
    parameter int SAMPLE_HZ      = 100,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst_L,
    input  logic                        i_Enable,
    euler_angle_reader_if.master        rd,
    output logic [15:0]                 o_Heading_Raw,
    output logic [15:0]                 o_Roll_Raw,
    output logic [15:0]                 o_Pitch_Raw,
    output logic                        o_Valid,
    output logic [7:0]                  o_Err_Count,
    output logic                        o_Stale
);
    localparam int PERIOD = CLK_HZ / SAMPLE_HZ;
    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(PERIOD - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RECV = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [2:0]         idx_q, idx_d;
    logic               bad_q, bad_d;
    logic [47:0]        shadow_q, shadow_d;
    logic [15:0]        head_q, head_d;
    logic [15:0]        roll_q, roll_d;
    logic [15:0]        pitch_q, pitch_d;
    logic               valid_q, valid_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic               stale_q, stale_d;

    logic               tick;
    logic               active;
    logic               timeout;
    logic               done;
    logic               byte_take;
    logic [3:0]         total;
    logic               frame_good;
    logic               frame_bad;

    // Tick fires in the cycle the counter wraps back to 0.
    assign tick = i_Enable && (tick_cnt_q == TICK_LAST);

    assign active    = (state_q != S_IDLE);
    assign timeout   = active && (to_q == TO_LAST);
    assign done      = (state_q == S_RECV) && rd.i_Rd_Done;
    assign byte_take = (state_q == S_RECV) && rd.i_Byte_Valid;

    // Byte count including one arriving alongside i_Rd_Done.
    assign total = {1'b0, idx_q} + {3'b000, byte_take};

    assign frame_good = done && !rd.i_Rd_Err && !bad_q &&
                        (total == 4'd6);
    // A done in the timeout cycle takes precedence over the timeout.
    assign frame_bad  = (done && !frame_good) || (timeout && !done);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (tick) state_d = S_REQ;
            end
            S_REQ: begin
                if (timeout)          state_d = S_IDLE;
                else if (rd.i_Rd_Ack) state_d = S_RECV;
            end
            S_RECV: begin
                if (done || timeout) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd.o_Rd_Req  = (state_q == S_REQ);
        rd.o_Rd_Addr = 8'h1A;
        rd.o_Rd_Len  = 3'd6;
    end

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        to_d       = to_q;
        idx_d      = idx_q;
        bad_d      = bad_q;
        shadow_d   = shadow_q;
        head_d     = head_q;
        roll_d     = roll_q;
        pitch_d    = pitch_q;
        valid_d    = 1'b0;
        err_cnt_d  = err_cnt_q;
        stale_d    = stale_q;

        if (!i_Enable || tick) tick_cnt_d = '0;
        else                   tick_cnt_d = tick_cnt_q + CNT_W'(1);

        if ((state_q == S_IDLE) && tick) begin
            idx_d = 3'd0;
            bad_d = 1'b0;
            to_d  = '0;
        end else if (active) begin
            to_d = to_q + TO_W'(1);
        end

        if (byte_take) begin
            if (idx_q < 3'd6) idx_d = idx_q + 3'd1;
            else              bad_d = 1'b1;
        end
        for (int i = 0; i < 6; i++) begin
            if (byte_take && (idx_q == 3'(i)))
                shadow_d[8*i +: 8] = rd.i_Byte;
        end

        // shadow_d so a final byte in the done cycle is included.
        if (frame_good) begin
            head_d  = shadow_d[15:0];
            roll_d  = shadow_d[31:16];
            pitch_d = shadow_d[47:32];
            valid_d = 1'b1;
            stale_d = 1'b0;
        end
        if (frame_bad) begin
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            stale_d = 1'b1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            tick_cnt_q <= '0;
            to_q       <= '0;
            idx_q      <= 3'd0;
            bad_q      <= 1'b0;
            shadow_q   <= '0;
            head_q     <= '0;
            roll_q     <= '0;
            pitch_q    <= '0;
            valid_q    <= 1'b0;
            err_cnt_q  <= '0;
            stale_q    <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            to_q       <= to_d;
            idx_q      <= idx_d;
            bad_q      <= bad_d;
            shadow_q   <= shadow_d;
            head_q     <= head_d;
            roll_q     <= roll_d;
            pitch_q    <= pitch_d;
            valid_q    <= valid_d;
            err_cnt_q  <= err_cnt_d;
            stale_q    <= stale_d;
        end
    end

    assign o_Heading_Raw = head_q;
    assign o_Roll_Raw    = roll_q;
    assign o_Pitch_Raw   = pitch_q;
    assign o_Valid       = valid_q;
    assign o_Err_Count   = err_cnt_q;
    assign o_Stale       = stale_q;
endmodule
